// File: rtl/tx_arb.sv
// tx_arb: four-requester round-robin byte arbiter in front of a UART serializer.
// A selected byte is offered until the serializer acks it (rising edge of tx_ack).
// If no ack arrives within TMO_TICKS baud ticks, the offer is abandoned.
module tx_arb #(
    parameter int unsigned MAX_BURST = 2,
    parameter int unsigned TMO_TICKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  gnt,
    output logic [3:0]  err,
    input  logic        tx_bd_en,
    output logic        tx_rdy,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    output logic        busy,
    output logic [1:0]  cur_id
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned BW   = 4;
    localparam int unsigned TW   = 8;

    typedef enum logic [1:0] {IDLE, OFFER, ABORT} state_t;

    state_t          state, state_d;
    logic            tx_rdy_d;
    logic [DW-1:0]   tx_data_d;
    logic [NREQ-1:0] gnt_d, err_d;
    logic            busy_d;
    logic [IDW-1:0]  cur_id_d;
    logic [IDW-1:0]  ptr, ptr_d;
    logic [BW-1:0]   burst_cnt, burst_d;
    logic [TW-1:0]   tick_cnt, tick_d;
    logic            ack_q;

    logic            ack_edge_c;
    logic            grant_c;
    logic            win_vld_c;
    logic [IDW-1:0]  win_id_c;
    logic [IDW-1:0]  idx_c;

    assign ack_edge_c = tx_ack & ~ack_q;
    assign grant_c    = ack_edge_c && (state != IDLE);

    // Winner selection: sticky last winner while its burst allowance lasts, else rotate from ptr+1.
    // burst_cnt==0 means no winner since reset, so the sticky rule does not apply then.
    always_comb begin
        win_vld_c = 1'b0;
        win_id_c  = ptr;
        idx_c     = ptr;
        if (req[ptr] && (burst_cnt != '0) && (burst_cnt < BW'(MAX_BURST))) begin
            win_vld_c = 1'b1;
            win_id_c  = ptr;
        end else begin
            for (int i = NREQ; i >= 1; i--) begin
                idx_c = ptr + IDW'(i);
                if (req[idx_c]) begin
                    win_vld_c = 1'b1;
                    win_id_c  = idx_c;
                end
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state;
        tx_rdy_d  = tx_rdy;
        tx_data_d = tx_data;
        gnt_d     = '0;
        err_d     = '0;
        cur_id_d  = cur_id;
        ptr_d     = ptr;
        burst_d   = burst_cnt;
        tick_d    = tick_cnt;

        if (grant_c) begin
            // An ack edge wins over a timeout in the same cycle and over the ABORT error path.
            state_d  = IDLE;
            tx_rdy_d = 1'b0;
            gnt_d    = NREQ'(1) << cur_id;
            ptr_d    = cur_id;
            if (cur_id == ptr && burst_cnt != '0) begin
                burst_d = (burst_cnt >= BW'(MAX_BURST)) ? burst_cnt : burst_cnt + BW'(1);
            end else begin
                burst_d = BW'(1);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld_c) begin
                        state_d   = OFFER;
                        tx_rdy_d  = 1'b1;
                        tx_data_d = req_data[DW*win_id_c +: DW];
                        cur_id_d  = win_id_c;
                        tick_d    = '0;
                    end
                end
                OFFER: begin
                    if (tx_bd_en) begin
                        tick_d = tick_cnt + TW'(1);
                        if (tick_cnt == TW'(TMO_TICKS - 1)) begin
                            state_d  = ABORT;
                            tx_rdy_d = 1'b0;
                        end
                    end
                end
                ABORT: begin
                    // Saturated burst count forces the next selection to rotate away.
                    state_d = IDLE;
                    err_d   = NREQ'(1) << cur_id;
                    ptr_d   = cur_id;
                    burst_d = BW'(MAX_BURST);
                end
                default: begin
                    state_d  = IDLE;
                    tx_rdy_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_rdy    <= 1'b0;
            tx_data   <= '0;
            gnt       <= '0;
            err       <= '0;
            busy      <= 1'b0;
            cur_id    <= '0;
            ptr       <= IDW'(3);
            burst_cnt <= '0;
            tick_cnt  <= '0;
            ack_q     <= 1'b0;
        end else begin
            state     <= state_d;
            tx_rdy    <= tx_rdy_d;
            tx_data   <= tx_data_d;
            gnt       <= gnt_d;
            err       <= err_d;
            busy      <= busy_d;
            cur_id    <= cur_id_d;
            ptr       <= ptr_d;
            burst_cnt <= burst_d;
            tick_cnt  <= tick_d;
            ack_q     <= tx_ack;
        end
    end

endmodule

// File: tb/tb_tx_arb.sv
// Directed bench for tx_arb: a default instance (MAX_BURST=2) and a MAX_BURST=1 instance.
module tb_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_a = '0, req_b = '0;
    logic [31:0] rdata = 32'hC3_A5_3C_5A;
    logic        ack = 1'b0;
    logic        bd = 1'b0;
    logic        sel = 1'b0;

    logic [3:0]  gnt_a, err_a, gnt_b, err_b;
    logic        rdy_a, rdy_b, busy_a, busy_b;
    logic [7:0]  data_a, data_b;
    logic [1:0]  id_a, id_b;
    logic        ack_a, ack_b;

    logic [3:0]  gnt_m, err_m;
    logic        rdy_m, busy_m;
    logic [7:0]  data_m;
    logic [1:0]  id_m;

    int n_tests = 0;
    int n_fail  = 0;

    assign ack_a  = ack & ~sel;
    assign ack_b  = ack & sel;
    assign gnt_m  = sel ? gnt_b  : gnt_a;
    assign err_m  = sel ? err_b  : err_a;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign data_m = sel ? data_b : data_a;
    assign id_m   = sel ? id_b   : id_a;

    always #5 clk = ~clk;

    tx_arb #(.MAX_BURST(2), .TMO_TICKS(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_data(rdata),
        .gnt(gnt_a), .err(err_a), .tx_bd_en(bd), .tx_rdy(rdy_a),
        .tx_data(data_a), .tx_ack(ack_a), .busy(busy_a), .cur_id(id_a)
    );

    tx_arb #(.MAX_BURST(1), .TMO_TICKS(32)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(rdata),
        .gnt(gnt_b), .err(err_b), .tx_bd_en(1'b0), .tx_rdy(rdy_b),
        .tx_data(data_b), .tx_ack(ack_b), .busy(busy_b), .cur_id(id_b)
    );

    typedef struct {
        logic       rr;
        logic [3:0] req;
        logic [1:0] id;
        int         dly;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rdy", 32'(rdy_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for an offer, check it, ack after dly cycles, check the grant pulse.
    task automatic serve(input logic [1:0] id, input int dly, input bit drop);
        int n = 0;
        logic [7:0] exp_d;
        exp_d = rdata[8*id +: 8];
        while (!rdy_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 1);
        chk("cur_id", 32'(id_m), 32'(id));
        chk("tx_data", 32'(data_m), 32'(exp_d));
        if (drop) begin
            if (sel) req_b = '0; else req_a = '0;
        end
        repeat (dly) @(negedge clk);
        chk("hold_rdy", 32'(rdy_m), 1);
        chk("hold_data", 32'(data_m), 32'(exp_d));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("gnt", 32'(gnt_m), 32'(4'b0001 << id));
        chk("err_quiet", 32'(err_m), 0);
        chk("rdy_drop", 32'(rdy_m), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy0", 32'(rdy_a), 0);
        chk("rst_data0", 32'(data_a), 0);
        chk("rst_gnt0", 32'(gnt_a), 0);
        chk("rst_err0", 32'(err_a), 0);
        chk("rst_id0", 32'(id_a), 0);
        rst_n = 1'b1;

        // Single byte, req dropped mid-offer: byte still granted
        do_reset();
        req_a = 4'b0001;
        serve(2'd0, 3, 1'b1);
        chk("single_busy", 32'(busy_a), 0);
        @(negedge clk);
        chk("single_idle", 32'(rdy_a), 0);

        // Round-robin (MAX_BURST=1) then bursts (MAX_BURST=2)
        vecs[0]  = '{1'b1, 4'b1111, 2'd0, 0};
        vecs[1]  = '{1'b1, 4'b1111, 2'd1, 1};
        vecs[2]  = '{1'b1, 4'b1111, 2'd2, 2};
        vecs[3]  = '{1'b1, 4'b1111, 2'd3, 0};
        vecs[4]  = '{1'b1, 4'b1111, 2'd0, 3};
        vecs[5]  = '{1'b0, 4'b0011, 2'd0, 0};
        vecs[6]  = '{1'b0, 4'b0011, 2'd0, 2};
        vecs[7]  = '{1'b0, 4'b0011, 2'd1, 1};
        vecs[8]  = '{1'b0, 4'b0011, 2'd1, 0};
        vecs[9]  = '{1'b0, 4'b0011, 2'd0, 4};
        vecs[10] = '{1'b0, 4'b0011, 2'd0, 0};
        vecs[11] = '{1'b0, 4'b1100, 2'd2, 1};
        vecs[12] = '{1'b0, 4'b1100, 2'd2, 0};
        vecs[13] = '{1'b0, 4'b1100, 2'd3, 2};
        vecs[14] = '{1'b0, 4'b1001, 2'd3, 0};
        vecs[15] = '{1'b0, 4'b1001, 2'd0, 1};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].rr;
            if (vecs[i].rr) begin
                req_a = '0;
                req_b = vecs[i].req;
            end else begin
                req_b = '0;
                req_a = vecs[i].req;
            end
            serve(vecs[i].id, vecs[i].dly, 1'b0);
        end
        req_a = '0;
        req_b = '0;
        sel   = 1'b0;

        // Timeout with a tick every 4th clock; waiting req[3] served next
        do_reset();
        req_a = 4'b0100;
        @(negedge clk);
        chk("tmo_offer", 32'(rdy_a), 1);
        req_a = 4'b1100;
        for (int k = 1; k <= 32; k++) begin
            bd = 1'b1;
            @(negedge clk);
            bd = 1'b0;
            if (k == 31) chk("tmo_pre", 32'(rdy_a), 1);
            if (k < 32) repeat (3) @(negedge clk);
        end
        chk("tmo_drop", 32'(rdy_a), 0);
        chk("tmo_abort_busy", 32'(busy_a), 1);
        chk("tmo_err_early", 32'(err_a), 0);
        @(negedge clk);
        chk("tmo_err", 32'(err_a), 32'h4);
        chk("tmo_no_gnt", 32'(gnt_a), 0);
        req_a = 4'b1000;
        serve(2'd3, 1, 1'b0);
        req_a = '0;

        // Ack edge in the ABORT cycle wins over the error
        do_reset();
        req_a = 4'b0100;
        @(negedge clk);
        chk("race_offer", 32'(rdy_a), 1);
        bd = 1'b1;
        repeat (31) @(negedge clk);
        chk("race_pre", 32'(rdy_a), 1);
        @(negedge clk);
        bd = 1'b0;
        chk("race_abort", 32'(rdy_a), 0);
        ack = 1'b1;
        req_a = '0;
        @(negedge clk);
        ack = 1'b0;
        chk("race_gnt", 32'(gnt_a), 32'h4);
        chk("race_no_err", 32'(err_a), 0);
        @(negedge clk);
        chk("race_no_err2", 32'(err_a), 0);
        chk("race_gnt_pulse", 32'(gnt_a), 0);

        // Reset mid-offer: async drop, byte lost, search restarts from 0
        do_reset();
        req_a = 4'b0010;
        @(negedge clk);
        chk("mid_offer", 32'(rdy_a), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(rdy_a), 0);
        chk("mid_rst_data", 32'(data_a), 0);
        chk("mid_rst_id", 32'(id_a), 0);
        req_a = 4'b1000;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt_a), 0);
        chk("mid_rst_err", 32'(err_a), 0);
        rst_n = 1'b1;
        serve(2'd3, 2, 1'b0);
        req_a = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
